mix_columns_iter: RTL and testbench
===================================

// Module: mix_columns_iter
// PURPOSE
//  Iterative, parametrised AES MixColumns engine with valid/ready handshakes on both sides.
//  Accepts one 128-bit state and transforms COLS_PER_CYCLE 32-bit columns per clock.
//  Trades area against latency, selected by the parameter.
//  Sits between ShiftRows and AddRoundKey in the round datapath.
//  Optionally also performs InvMixColumns, for the shared enc/dec core.
// PARAMETERS
//  COLS_PER_CYCLE  1  columns transformed per clock. Legal values: 1, 2, 4; any other value is an elaboration error.
//  NUM_BEATS       4/COLS_PER_CYCLE (localparam)  compute cycles per block.
// PORTS
//  clk        in   1    single clock; all state updates on the rising edge.
//  rst_n      in   1    synchronous, active-low reset.
//  in_valid   in   1    in_state/in_inv are valid.
//  in_ready   out  1    engine can accept a block this cycle.
//  in_state   in   128  input state; column c = bits [127-32c -: 32]; byte s0 is the MSB of the column.
//  in_inv     in   1    1 = InvMixColumns. Ignored unless INV_MIX_EN is defined.
//  out_valid  out  1    out_state holds a finished block.
//  out_ready  in   1    downstream accepts out_state.
//  out_state  out  128  transformed state, same layout as in_state.
// BEHAVIOUR
//  Reset (rst_n==0 at an edge):
//   - FSM goes to IDLE; beat counter = 0; out_valid = 0; out_state = 0; mode register = 0.
//   - in_ready is 0 while rst_n is low.
//   - Reset mid-block discards the block; nothing is output.
//  FSM states: IDLE -> BUSY -> DONE.
//   - IDLE: in_ready = 1. On in_valid & in_ready: capture in_state into the work register and latch in_inv; beat = 0; go to BUSY.
//   - BUSY: in_ready = 0, out_valid = 0.
//     - Each cycle, replace columns beat*CPC .. beat*CPC+CPC-1 of the work register with their transform.
//     - Column 0 is transformed first. Untouched columns hold their value.
//     - beat wraps to 0 after NUM_BEATS-1, and the FSM goes to DONE.
//   - DONE: out_valid = 1; out_state = work register, stable while out_ready = 0.
//     - in_ready = out_ready (combinational).
//     - out_ready & ~in_valid: go to IDLE.
//     - out_ready & in_valid (simultaneous): output is retired and the new block is captured in the same edge; go directly to BUSY (no bubble).
//  Latency: accepting edge -> out_valid high after NUM_BEATS edges (4 / 2 / 1 for CPC = 1 / 2 / 4).
//  Throughput: one block per NUM_BEATS+1 cycles with out_ready held high.
//  Forward per column, GF(2^8) with poly 0x11B, xtime(x) = x<<1 ^ (x[7] ? 8'h1B : 0):
//   - r0 = 2s0^3s1^s2^s3
//   - r1 = s0^2s1^3s2^s3
//   - r2 = s0^s1^2s2^3s3
//   - r3 = 3s0^s1^s2^2s3
//  Inverse per column uses the circulant coefficients {0e, 0b, 0d, 09}:
//   - r0 = 0e*s0 ^ 0b*s1 ^ 0d*s2 ^ 09*s3, rotated for r1..r3.
//  in_inv is sampled only on the capture edge; changes during BUSY or DONE have no effect.
//  in_state is not required to be held after capture.
// CONFIGURATION
//  INV_MIX_EN defined:
//   - Inverse datapath is built.
//   - Latched in_inv = 1 selects InvMixColumns for the whole block.
//  INV_MIX_EN undefined:
//   - Only the forward datapath is built; in_inv is ignored and the mode register is removed.
//   - All blocks use forward MixColumns.
// TESTING  (run every scenario for COLS_PER_CYCLE = 1, 2, 4)
//  1. FIPS-197 forward vector:
//     - in_state = 128'hdb135345_f20a225c_01010101_c6c6c6c6
//     - -> out_state = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6
//     - out_valid rises exactly NUM_BEATS edges after acceptance.
//  2. INV_MIX_EN, in_inv = 1:
//     - in_state = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8
//     - -> out_state = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c
//     - Without INV_MIX_EN, the same input yields the forward transform.
//  3. Backpressure:
//     - Hold out_ready = 0 for 10 cycles after out_valid.
//     - -> out_state and out_valid stay stable; in_ready = 0 throughout.
//     - Release -> single transfer, then IDLE.
//  4. Back-to-back:
//     - out_ready = 1 and in_valid = 1 every cycle, 8 random blocks.
//     - -> in_ready pulses in DONE; one result per NUM_BEATS+1 cycles; results match the golden model in order.
//  5. Reset mid-block:
//     - Drop rst_n for 1 cycle at beat 1 of BUSY.
//     - -> out_valid = 0, out_state = 0; no output for the aborted block.
//     - The next block is processed correctly.
//  6. Mode isolation:
//     - Toggle in_inv and in_state during BUSY.
//     - -> result depends only on values captured at acceptance.

Source files
------------

// File: rtl/mix_columns_iter.sv
// mix_columns_iter: iterative AES MixColumns engine with valid/ready on both sides.
// Transforms COLS_PER_CYCLE 32-bit columns per clock (1, 2 or 4), so a block takes
// 4/COLS_PER_CYCLE compute cycles. Column c of the state is bits [127-32c -: 32].
// Build option: define INV_MIX_EN to add the InvMixColumns datapath, which is selected
// per block by in_inv as it was sampled at acceptance.
`timescale 1ns/1ps

module mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    localparam int NUM_BEATS = 4 / COLS_PER_CYCLE;

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
            $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // GF(2^8) multiply by 2, reduction polynomial 0x11B
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // Forward MixColumns on one column; s0 is the most significant byte
    function automatic logic [31:0] mix_fwd(input logic [31:0] col);
        logic [7:0] s0, s1, s2, s3;
        logic [7:0] d0, d1, d2, d3;
        {s0, s1, s2, s3} = col;
        d0 = xtime(s0);
        d1 = xtime(s1);
        d2 = xtime(s2);
        d3 = xtime(s3);
        return {d0 ^ d1 ^ s1 ^ s2 ^ s3,
                s0 ^ d1 ^ d2 ^ s2 ^ s3,
                s0 ^ s1 ^ d2 ^ d3 ^ s3,
                d0 ^ s0 ^ s1 ^ s2 ^ d3};
    endfunction

`ifdef INV_MIX_EN
    // Inverse MixColumns on one column: circulant {0e, 0b, 0d, 09}
    function automatic logic [31:0] mix_inv(input logic [31:0] col);
        logic [3:0][7:0] s, x2, x4, x8, m9, mb, md, me;
        s = col;
        for (int i = 0; i < 4; i++) begin
            x2[i] = xtime(s[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ s[i];
            mb[i] = x8[i] ^ x2[i] ^ s[i];
            md[i] = x8[i] ^ x4[i] ^ s[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        // s[3] is byte s0 (MSB), s[0] is byte s3
        return {me[3] ^ mb[2] ^ md[1] ^ m9[0],
                m9[3] ^ me[2] ^ mb[1] ^ md[0],
                md[3] ^ m9[2] ^ me[1] ^ mb[0],
                mb[3] ^ md[2] ^ m9[1] ^ me[0]};
    endfunction
`endif

    state_e            state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic [3:0][31:0]  work_q, work_d;   // element 3 is column 0
    logic              out_valid_q, out_valid_d;
    logic              capture;
    logic [1:0]        col_slot;

`ifdef INV_MIX_EN
    logic              mode_q, mode_d;
`else
    logic              unused_in_inv;
    assign unused_in_inv = in_inv;
`endif

    // Upstream handshake: open in IDLE, follows out_ready in DONE, closed in reset
    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_IDLE:  in_ready = 1'b1;
                S_DONE:  in_ready = out_ready;
                default: in_ready = 1'b0;
            endcase
        end
    end

    // Next-state, beat counter and work-register update
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves a latch behind.
        state_d     = state_q;
        beat_d      = beat_q;
        work_d      = work_q;
        out_valid_d = out_valid_q;
        capture     = 1'b0;
        col_slot    = 2'd0;
`ifdef INV_MIX_EN
        mode_d      = mode_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) capture = 1'b1;
            end
            S_BUSY: begin
                for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                    col_slot = 2'(3 - (int'(beat_q) * COLS_PER_CYCLE + k));
`ifdef INV_MIX_EN
                    work_d[col_slot] = mode_q ? mix_inv(work_q[col_slot])
                                              : mix_fwd(work_q[col_slot]);
`else
                    work_d[col_slot] = mix_fwd(work_q[col_slot]);
`endif
                end
                if (beat_q == 2'(NUM_BEATS - 1)) begin
                    beat_d      = 2'd0;
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (in_valid) capture = 1'b1;
                    else          state_d = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        // Retiring a result and accepting the next block can share one edge
        if (capture) begin
            work_d  = in_state;
            beat_d  = 2'd0;
            state_d = S_BUSY;
`ifdef INV_MIX_EN
            mode_d  = in_inv;
`endif
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            beat_q      <= 2'd0;
            out_valid_q <= 1'b0;
            // NOTE: the work register is also the visible out_state, so it is cleared on reset.
            work_q      <= '0;
`ifdef INV_MIX_EN
            mode_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            out_valid_q <= out_valid_d;
            work_q      <= work_d;
`ifdef INV_MIX_EN
            mode_q      <= mode_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_state = work_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// tb_mix_columns_iter: directed self-checking bench for mix_columns_iter.
// Honours INV_MIX_EN the same way the design does; CPC selects the column parallelism.
`timescale 1ns/1ps

module tb_mix_columns_iter;

    parameter int CPC = 1;
    localparam int NB = 4 / CPC;

    localparam logic [127:0] FIPS_FWD_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] FIPS_FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] INV_IN       = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
    localparam logic [127:0] INV_OUT      = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
    localparam logic [127:0] R1_IN        = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] R1_OUT       = 128'h046681e5_e0cb199a_48f8d37a_2806264c;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_inv = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_state = '0;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] out_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mix_columns_iter #(.COLS_PER_CYCLE(CPC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    // Generic shift-and-add GF(2^8) multiply
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] model_col(input logic [31:0] col, input bit inv);
        logic [7:0] c [4];
        logic [7:0] s [4];
        logic [7:0] acc;
        logic [31:0] r = '0;
        if (inv) c = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     c = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int j = 0; j < 4; j++) s[j] = col[31-8*j -: 8];
        for (int i = 0; i < 4; i++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc ^= gmul(c[(j - i + 4) % 4], s[j]);
            r[31-8*i -: 8] = acc;
        end
        return r;
    endfunction

    function automatic logic [127:0] model_state(input logic [127:0] st, input bit inv);
        logic [127:0] r = '0;
        for (int c = 0; c < 4; c++) r[127-32*c -: 32] = model_col(st[127-32*c -: 32], inv);
        return r;
    endfunction

    function automatic bit eff_inv(input bit inv);
`ifdef INV_MIX_EN
        return inv;
`else
        return inv & 1'b0;
`endif
    endfunction

    task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Offer a block, wait for acceptance, then scramble inputs until out_valid (bounded)
    task automatic run_block(input logic [127:0] st, input bit inv, input string tag, output int lat);
        int w;
        @(negedge clk);
        in_state = st;
        in_inv   = inv;
        in_valid = 1'b1;
        #1;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        check_bit({tag, "_accept_ready"}, in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            in_state = {$urandom, $urandom, $urandom, $urandom};
            in_inv   = ~in_inv;
            @(posedge clk);
            #1;
            lat++;
        end
        check_int({tag, "_latency"}, lat, NB);
    endtask

    // Retire a finished block with in_valid low: expect a single transfer and IDLE
    task automatic retire(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check_bit({tag, "_ready_in_done"}, in_ready, 1'b1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_bit({tag, "_valid_drop"}, out_valid, 1'b0);
        check_bit({tag, "_idle_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int lat;
        int sent, recv, cyc, last, seen;
        logic [127:0] blk  [8];
        logic [127:0] expq [8];
        bit           binv [8];

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_bit("rst_in_ready", in_ready, 1'b0);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_vec("rst_out_state", out_state, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_bit("idle_in_ready", in_ready, 1'b1);

        // FIPS-197 forward vector
        run_block(FIPS_FWD_IN, 1'b0, "fips_fwd", lat);
        check_vec("fips_fwd_data", out_state, FIPS_FWD_OUT);
        retire("fips_fwd");

        // Inverse request (forward when the inverse datapath is not built)
        run_block(INV_IN, 1'b1, "inv", lat);
`ifdef INV_MIX_EN
        check_vec("inv_data", out_state, INV_OUT);
`else
        check_vec("inv_data_fwd", out_state, model_state(INV_IN, 1'b0));
`endif
        retire("inv");

        // Backpressure: hold out_ready low for 10 cycles
        run_block(R1_IN, 1'b0, "bp", lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_state = {$urandom, $urandom, $urandom, $urandom};
            #1;
            check_bit("bp_valid_hold", out_valid, 1'b1);
            check_vec("bp_state_hold", out_state, R1_OUT);
            check_bit("bp_in_ready_low", in_ready, 1'b0);
        end
        retire("bp");

        // Back-to-back: in_valid and out_ready high, 8 random blocks
        for (int i = 0; i < 8; i++) begin
            blk[i]  = {$urandom, $urandom, $urandom, $urandom};
            binv[i] = i[0];
            expq[i] = model_state(blk[i], eff_inv(binv[i]));
        end
        sent = 0; recv = 0; cyc = 0; last = 0;
        out_ready = 1'b1;
        while (recv < 8 && cyc < 200) begin
            @(negedge clk);
            if (sent < 8) begin
                in_valid = 1'b1;
                in_state = blk[sent];
                in_inv   = binv[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                check_vec($sformatf("b2b_data%0d", recv), out_state, expq[recv]);
                check_bit("b2b_ready_in_done", in_ready, 1'b1);
                if (recv > 0) check_int("b2b_spacing", cyc - last, NB + 1);
                last = cyc;
                recv++;
            end
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        check_int("b2b_count", recv, 8);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_bit("b2b_drained", out_valid, 1'b0);

        // Reset mid-block
        @(negedge clk);
        in_state = INV_IN;
        in_inv   = 1'b0;
        in_valid = 1'b1;
        #1;
        check_bit("rmb_accept_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (NB > 1) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_bit("rmb_in_ready_low", in_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_bit("rmb_out_valid", out_valid, 1'b0);
        check_vec("rmb_out_state", out_state, '0);
        check_bit("rmb_idle_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        check_int("rmb_no_output", seen, 0);
        run_block(FIPS_FWD_IN, 1'b0, "rmb_next", lat);
        check_vec("rmb_next_data", out_state, FIPS_FWD_OUT);
        retire("rmb_next");

        // Mode isolation: run_block toggles in_inv and in_state throughout BUSY
        run_block(R1_IN, 1'b0, "iso_fwd", lat);
        check_vec("iso_fwd_data", out_state, R1_OUT);
        retire("iso_fwd");
        run_block(FIPS_FWD_OUT, 1'b1, "iso_inv", lat);
`ifdef INV_MIX_EN
        check_vec("iso_inv_data", out_state, FIPS_FWD_IN);
`else
        check_vec("iso_inv_data_fwd", out_state, model_state(FIPS_FWD_OUT, 1'b0));
`endif
        retire("iso_inv");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
